// File: rtl/food_spawn_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// food_spawn_ctrl_pkg : shared game constants and spawn FSM state enum. Rev 1.0
// ---------------------------------------------------------------------------
package food_spawn_ctrl_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int COORD_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW_X = 3'd1,
    ST_DRAW_Y = 3'd2,
    ST_QUERY  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } spawn_state_e;

endpackage
`default_nettype wire

// File: rtl/food_spawn_ctrl_lfsr6.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr6 : free-running 6-bit maximal-length LFSR (period 63). Rev 1.0
// ---------------------------------------------------------------------------
module lfsr6 #(
  parameter logic [5:0] SEED = 6'd1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] q_o
);
  import food_spawn_ctrl_pkg::*;

  logic [COORD_W-1:0] q_q;
  logic [COORD_W-1:0] q_d;

  // Right-shift Fibonacci form of x^6 + x + 1; the all-zero state is unreachable.
  assign q_d = {q_q[0] ^ q_q[1], q_q[5:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/food_spawn_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// food_spawn_ctrl : draws random in-grid cells and checks occupancy until one is free. Rev 1.0
// ---------------------------------------------------------------------------
module food_spawn_ctrl #(
  parameter int         GRID_W    = food_spawn_ctrl_pkg::GRID_W,
  parameter int         GRID_H    = food_spawn_ctrl_pkg::GRID_H,
  parameter int         MAX_TRIES = 16,
  parameter logic [5:0] SEED      = 6'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn_req_i,
  output logic       spawn_busy_o,
  output logic       occ_query_o,
  output logic [5:0] occ_x_o,
  output logic [5:0] occ_y_o,
  input  logic       occ_ack_i,
  input  logic       occ_hit_i,
  output logic [5:0] food_x_o,
  output logic [5:0] food_y_o,
  output logic       food_valid_o,
  output logic       spawn_fail_o
);
  import food_spawn_ctrl_pkg::*;

  localparam logic [COORD_W-1:0] LIMIT_X   = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] LIMIT_Y   = COORD_W'(GRID_H);
  localparam logic [7:0]         TRY_LIMIT = 8'(MAX_TRIES);

  spawn_state_e       state_q, state_d;
  logic [7:0]         tries_q, tries_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d;
  logic [COORD_W-1:0] cand_y_q, cand_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d;
  logic [COORD_W-1:0] food_y_q, food_y_d;
  logic [COORD_W-1:0] lfsr_q;
  logic [COORD_W-1:0] coord;

  lfsr6 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q_o   (lfsr_q)
  );

  // LFSR never reaches 0, so subtracting 1 maps it onto 0..62.
  assign coord = lfsr_q - 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      food_x_q <= '0;
      food_y_q <= '0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    unique case (state_q)
      ST_IDLE: begin
        if (spawn_req_i) begin
          state_d = ST_DRAW_X;
          tries_d = '0;
        end
      end
      ST_DRAW_X: begin
        if (coord < LIMIT_X) begin
          cand_x_d = coord;
          state_d  = ST_DRAW_Y;
        end
      end
      ST_DRAW_Y: begin
        if (coord < LIMIT_Y) begin
          cand_y_d = coord;
          state_d  = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (occ_ack_i) begin
          if (!occ_hit_i) begin
            // Food registers load on entry to DONE so they align with the pulse.
            state_d  = ST_DONE;
            food_x_d = cand_x_q;
            food_y_d = cand_y_q;
          end else begin
            tries_d = tries_q + 8'd1;
            state_d = (tries_d == TRY_LIMIT) ? ST_FAIL : ST_DRAW_X;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spawn_busy_o = (state_q != ST_IDLE);
    occ_query_o  = (state_q == ST_QUERY);
    food_valid_o = (state_q == ST_DONE);
    spawn_fail_o = (state_q == ST_FAIL);
  end

  assign occ_x_o  = cand_x_q;
  assign occ_y_o  = cand_y_q;
  assign food_x_o = food_x_q;
  assign food_y_o = food_y_q;

endmodule
`default_nettype wire

// File: tb/tb_food_spawn_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_food_spawn_ctrl : directed self-checking bench for food_spawn_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
module tb_food_spawn_ctrl;

  localparam int GW = 40;
  localparam int GH = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spawn_req = 1'b0;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic       spawn_busy, occ_query, food_valid, spawn_fail;
  logic [5:0] occ_x, occ_y, food_x, food_y;
  logic [5:0] model;
  int         errors = 0;
  int         checks = 0;

  food_spawn_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(16), .SEED(6'd1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .spawn_req_i  (spawn_req),
    .spawn_busy_o (spawn_busy),
    .occ_query_o  (occ_query),
    .occ_x_o      (occ_x),
    .occ_y_o      (occ_y),
    .occ_ack_i    (occ_ack),
    .occ_hit_i    (occ_hit),
    .food_x_o     (food_x),
    .food_y_o     (food_y),
    .food_valid_o (food_valid),
    .spawn_fail_o (spawn_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lfsr_next(input logic [5:0] r);
    return {r[0] ^ r[1], r[5:1]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model <= 6'd1;
    else       model <= lfsr_next(model);
  end

  // v0 is the LFSR value seen during the first DRAW_X cycle.
  task automatic predict(input logic [5:0] v0, output logic [5:0] x, output logic [5:0] y,
                         output int lat);
    logic [5:0] v;
    v   = v0;
    lat = 0;
    while (6'(v - 6'd1) >= 6'(GW)) begin v = lfsr_next(v); lat++; end
    x = 6'(v - 6'd1);
    v = lfsr_next(v);
    while (6'(v - 6'd1) >= 6'(GH)) begin v = lfsr_next(v); lat++; end
    y = 6'(v - 6'd1);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (spawn_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", spawn_busy); end
    checks++; if (occ_query !== 1'b0) begin errors++; $display("FAIL reset_query: got %b want 0", occ_query); end
    checks++; if (food_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", food_valid); end
    checks++; if (spawn_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", spawn_fail); end
    checks++; if ({food_x, food_y, occ_x, occ_y} !== 24'd0) begin errors++;
      $display("FAIL reset_coords: got fx=%0d fy=%0d ox=%0d oy=%0d want all 0", food_x, food_y, occ_x, occ_y); end
    reset = 1'b0;
  endtask

  task automatic test_lfsr;
    int bad = 0;
    checks++; if (u_dut.u_lfsr.q_o !== 6'd1) begin errors++; $display("FAIL lfsr_seed: got %0d want 1", u_dut.u_lfsr.q_o); end
    tick;
    checks++; if (u_dut.u_lfsr.q_o !== 6'd32) begin errors++; $display("FAIL lfsr_step1: got %0d want 32", u_dut.u_lfsr.q_o); end
    for (int i = 0; i < 63; i++) begin
      if (u_dut.u_lfsr.q_o !== model) bad++;
      tick;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lfsr_seq: got %0d mismatching cycles want 0", bad); end
    checks++; if (u_dut.u_lfsr.q_o !== 6'd32) begin errors++; $display("FAIL lfsr_period: got %0d want 32 after 63 steps", u_dut.u_lfsr.q_o); end
  endtask

  task automatic test_single_spawn;
    logic [5:0] px, py, gx, gy;
    int lat, fv_at, pulses;
    occ_ack = 1'b1; occ_hit = 1'b0;
    fv_at = -1; pulses = 0; gx = '0; gy = '0; lat = 1;
    for (int k = 0; k < 64; k++) begin
      predict(lfsr_next(model), px, py, lat);
      if (lat == 0) break;
      tick;
    end
    spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0;
    checks++; if (spawn_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", spawn_busy); end
    for (int c = 1; c <= 8; c++) begin
      if (food_valid === 1'b1) begin
        pulses++;
        if (fv_at < 0) begin fv_at = c; gx = food_x; gy = food_y; end
      end
      tick;
    end
    checks++; if (fv_at != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", fv_at); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    checks++; if (gx !== px || gy !== py) begin errors++; $display("FAIL single_coord: got %0d,%0d want %0d,%0d", gx, gy, px, py); end
    checks++; if (gx >= 6'd40 || gy >= 6'd30) begin errors++; $display("FAIL single_range: got %0d,%0d want <40,<30", gx, gy); end
    checks++; if (spawn_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", spawn_busy); end
  endtask

  task automatic test_all_hit;
    logic [5:0] fx0, fy0;
    int queries, valids, fails, n;
    bit seen;
    fx0 = food_x; fy0 = food_y;
    queries = 0; valids = 0; fails = 0; seen = 1'b0; n = 0;
    occ_ack = 1'b1; occ_hit = 1'b1;
    spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0;
    while (!seen && n < 3000) begin
      if (occ_query === 1'b1) queries++;
      if (food_valid === 1'b1) valids++;
      if (spawn_fail === 1'b1) begin fails++; seen = 1'b1; end
      tick;
      n++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hit_timeout: got no spawn_fail within %0d cycles want pulse", n); end
    checks++; if (queries != 16) begin errors++; $display("FAIL hit_queries: got %0d want 16", queries); end
    checks++; if (valids != 0) begin errors++; $display("FAIL hit_valid: got %0d food_valid want 0", valids); end
    checks++; if (spawn_fail !== 1'b0 || spawn_busy !== 1'b0) begin errors++;
      $display("FAIL hit_pulse_end: got fail=%b busy=%b want 0,0", spawn_fail, spawn_busy); end
    checks++; if (food_x !== fx0 || food_y !== fy0) begin errors++;
      $display("FAIL hit_food_kept: got %0d,%0d want %0d,%0d", food_x, food_y, fx0, fy0); end
    occ_hit = 1'b0;
  endtask

  task automatic test_delayed_ack;
    logic [5:0] px, py, qx, qy;
    int lat, n, busy_seen;
    bit stable;
    occ_ack = 1'b0; occ_hit = 1'b0;
    spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0;
    predict(model, px, py, lat);
    occ_ack = 1'b1;
    tick;
    occ_ack = 1'b0;
    spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0;
    n = 0;
    while (occ_query !== 1'b1 && n < 200) begin tick; n++; end
    checks++; if (occ_query !== 1'b1) begin errors++; $display("FAIL delay_query_timeout: got no occ_query want query"); end
    qx = occ_x; qy = occ_y; stable = 1'b1;
    for (int q = 1; q <= 6; q++) begin
      if (occ_query !== 1'b1 || occ_x !== qx || occ_y !== qy) stable = 1'b0;
      if (q == 6) occ_ack = 1'b1;
      tick;
    end
    occ_ack = 1'b0;
    checks++; if (!stable) begin errors++; $display("FAIL delay_stable: got unstable query, last %0d,%0d want %0d,%0d", occ_x, occ_y, qx, qy); end
    checks++; if (food_valid !== 1'b1 || occ_query !== 1'b0) begin errors++;
      $display("FAIL delay_done: got valid=%b query=%b want 1,0", food_valid, occ_query); end
    checks++; if (food_x !== px || food_y !== py) begin errors++;
      $display("FAIL delay_coord: got %0d,%0d want %0d,%0d", food_x, food_y, px, py); end
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (spawn_busy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL delay_no_queue: got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_mid;
    int n, bad;
    occ_ack = 1'b0; occ_hit = 1'b0;
    spawn_req = 1'b1;
    tick;
    spawn_req = 1'b0;
    n = 0;
    while (occ_query !== 1'b1 && n < 200) begin tick; n++; end
    reset = 1'b1;
    #1;
    checks++; if (occ_query !== 1'b0 || spawn_busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_async: got query=%b busy=%b want 0,0", occ_query, spawn_busy); end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (food_valid !== 1'b0 || spawn_fail !== 1'b0 || spawn_busy !== 1'b0 || occ_query !== 1'b0) bad++;
      tick;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
    checks++; if (food_x !== 6'd0 || food_y !== 6'd0) begin errors++;
      $display("FAIL rstmid_food: got %0d,%0d want 0,0", food_x, food_y); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ex, ey;
    int lat, starts, pulses, range_bad, mis, n;
    logic prev_busy;
    starts = 0; pulses = 0; range_bad = 0; mis = 0; ex = '0; ey = '0;
    prev_busy = spawn_busy;
    occ_ack = 1'b1; occ_hit = 1'b0;
    spawn_req = 1'b1;
    for (int c = 0; c < 160; c++) begin
      if (c == 100) spawn_req = 1'b0;
      if (c >= 100 && spawn_busy !== 1'b1) break;
      if (spawn_busy === 1'b1 && prev_busy !== 1'b1) begin starts++; predict(model, ex, ey, lat); end
      if (food_valid === 1'b1) begin
        pulses++;
        if (food_x >= 6'd40 || food_y >= 6'd30) range_bad++;
        if (food_x !== ex || food_y !== ey) mis++;
      end
      prev_busy = spawn_busy;
      tick;
    end
    spawn_req = 1'b0;
    n = 0;
    while (spawn_busy === 1'b1 && n < 50) begin tick; n++; end
    checks++; if (pulses != starts) begin errors++; $display("FAIL b2b_pulses: got %0d pulses want %0d", pulses, starts); end
    checks++; if (starts < 5) begin errors++; $display("FAIL b2b_starts: got %0d spawns want >=5", starts); end
    checks++; if (range_bad != 0) begin errors++; $display("FAIL b2b_range: got %0d out of range want 0", range_bad); end
    checks++; if (mis != 0) begin errors++; $display("FAIL b2b_coord: got %0d coord mismatches want 0", mis); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lfsr();
    test_single_spawn();
    test_all_hit();
    test_delayed_ack();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/food_spawn_ctrl.md
FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 Parameter GRID_W, default 40, playfield width in cells; SHALL be in the range 1..63.
REQ-002 Parameter GRID_H, default 30, playfield height in cells; SHALL be in the range 1..63.
REQ-003 Parameter MAX_TRIES, default 16, occupied-cell rejections allowed before giving up; SHALL be in the range 1..255.
REQ-004 Parameter SEED, default 6'd1, LFSR reset value; SHALL be nonzero.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 spawn_req  input  1  request for a new food position; level or pulse.
REQ-008 spawn_busy  output  1  high while a spawn is in progress.
REQ-009 occ_query  output  1  occupancy lookup request to the snake-body logic.
REQ-010 occ_x, occ_y  output  6 each  candidate cell; SHALL be stable while occ_query is high.
REQ-011 occ_ack  input  1  lookup complete; sampled only while occ_query is high.
REQ-012 occ_hit  input  1  candidate cell is occupied; valid with occ_ack.
REQ-013 food_x, food_y  output  6 each  last accepted food cell.
REQ-014 food_valid  output  1  one-cycle pulse marking a new food_x/food_y.
REQ-015 spawn_fail  output  1  one-cycle pulse when MAX_TRIES is exhausted.

Function
REQ-016 The internal 6-bit LFSR SHALL advance every clock, independent of FSM state: next = {r[0]^r[1], r[5:1]}, maximal period 63, never 0.
REQ-017 The candidate coordinate SHALL be LFSR value minus 1, giving the range 0..62, computed in 6 bits.
REQ-018 FSM states SHALL be IDLE, DRAW_X, DRAW_Y, QUERY, DONE and FAIL.
REQ-019 IDLE: spawn_req=1 SHALL go to DRAW_X, clear the try counter and raise spawn_busy on the next cycle.
REQ-020 DRAW_X: if coord < GRID_W, capture it into cand_x and go to DRAW_Y; otherwise stay in DRAW_X and redraw next cycle, with no try consumed.
REQ-021 DRAW_Y: behaves like DRAW_X, using GRID_H and cand_y; on success go to QUERY.
REQ-022 QUERY: occ_query SHALL be high with occ_x=cand_x and occ_y=cand_y.
REQ-023 An occ_ack in the first QUERY cycle SHALL be accepted, giving zero-wait lookup.
REQ-024 occ_ack with occ_hit=0 SHALL go to DONE; occ_query SHALL drop the cycle after the ack.
REQ-025 occ_ack with occ_hit=1 SHALL increment tries.
REQ-026 After that increment: if tries == MAX_TRIES, go to FAIL; otherwise go to DRAW_X.
REQ-027 DONE: load food_x/food_y from cand_x/cand_y, pulse food_valid for exactly 1 cycle, then go to IDLE.
REQ-028 FAIL: pulse spawn_fail for 1 cycle, leave food_x/food_y unchanged, then go to IDLE.
REQ-029 spawn_busy SHALL be high in DRAW_X, DRAW_Y, QUERY, DONE and FAIL, and low only in IDLE.
REQ-030 spawn_req SHALL be ignored while spawn_busy is high; no queuing.
REQ-031 A spawn_req held high in the IDLE cycle after DONE or FAIL SHALL start a new spawn.
REQ-032 occ_ack received outside QUERY SHALL be ignored.
REQ-033 The try counter SHALL be 8 bits and SHALL NOT wrap, because REQ-026 ends the spawn first.
REQ-034 Minimum latency, from spawn_req to the food_valid pulse, SHALL be 4 cycles (DRAW_X, DRAW_Y, QUERY with immediate ack, DONE).

Reset
REQ-035 On reset: FSM SHALL be IDLE and the LFSR SHALL be SEED.
REQ-036 On reset: tries, cand_x, cand_y, food_x and food_y SHALL be 0.
REQ-037 On reset: occ_query, food_valid, spawn_fail and spawn_busy SHALL be 0.
REQ-038 Reset asserted mid-spawn SHALL abandon the spawn with no food_valid or spawn_fail pulse.

Structure
REQ-039 The shared game package SHALL hold GRID_W, GRID_H, the coordinate width (6) and the FSM state enum.
REQ-040 The LFSR SHALL be a separate sub-module, lfsr6, with clk, reset, a SEED parameter and a 6-bit q output; the FSM, try counter and candidate registers SHALL stay in food_spawn_ctrl.

Verification
REQ-041 Reset -> all outputs 0; the LFSR sequence from SEED=1 SHALL match a reference model for 63 cycles and then repeat.
REQ-042 spawn_req with ack and hit=0 on the first QUERY cycle -> food_valid exactly 4 cycles after the request; food_x < 40, food_y < 30, matching the model.
REQ-043 occ_hit=1 always, MAX_TRIES=16 -> exactly 16 queries, then a spawn_fail pulse, no food_valid, and food_x/food_y unchanged.
REQ-044 Ack delayed 5 cycles -> occ_x/occ_y constant for all 6 query cycles; a spurious occ_ack during DRAW_X has no effect.
REQ-045 Reset pulsed during QUERY -> next cycle in IDLE with occ_query=0, and no pulses ever appear.
REQ-046 spawn_req held high for 100 cycles with hit=0 -> back-to-back spawns, one food_valid per spawn, all coordinates in range.
